// File: rtl/tsa_multilane.sv
// Multi-lane TS analyzer: loads an expected TS via req/ack, counts matching TSs per lane, flags done per lane and in aggregate.
// Optional Link/Lane number capture per lane is enabled by defining TSA_LANE_CAPTURE_EN.
module tsa_multilane #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 8,
  parameter int TS_W      = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      exp_update,
  output logic                      exp_update_ack,
  input  logic [TS_W-1:0]           exp_ts,
  input  logic [TS_W-1:0]           exp_mask,
  input  logic [CNT_W-1:0]          exp_target,
  input  logic                      exp_consec,
  input  logic                      ts_stop,
  input  logic [NUM_LANES-1:0]      lane_en,
  input  logic                      tx_sent_enough,
  input  logic                      tx_gate_en,
  input  logic [NUM_LANES-1:0]      remote_ts_valid,
  input  logic [NUM_LANES*TS_W-1:0] remote_ts,
  output logic [NUM_LANES-1:0]      lane_done,
  output logic                      all_done,
  output logic                      any_done,
  output logic [NUM_LANES*8-1:0]    rcv_link_num,
  output logic [NUM_LANES*8-1:0]    rcv_lane_num,
  output logic [NUM_LANES-1:0]      rcv_vld
);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t                 r_state, w_state_next;
  logic                   r_ack;
  logic [TS_W-1:0]        r_exp_ts, r_exp_mask;
  logic [CNT_W-1:0]       r_exp_target;
  logic                   r_exp_consec;
  logic [NUM_LANES-1:0]   r_lane_done, w_lane_done_next;
  logic                   r_all_done, r_any_done;
  logic                   w_accept, w_count_en, w_gate;

  // An update held high during its own ack cycle must not be taken twice.
  assign w_accept = exp_update & ~r_ack;
  assign w_gate   = ~tx_gate_en | tx_sent_enough;

  always_comb begin
    w_state_next = r_state;
    w_count_en   = 1'b0;
    if (w_accept) begin
      w_state_next = ARMED;
    end else if (ts_stop) begin
      w_state_next = IDLE;
    end else begin
      w_count_en = (r_state == ARMED);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ack        <= 1'b0;
      r_exp_ts     <= '0;
      r_exp_mask   <= '0;
      r_exp_target <= '0;
      r_exp_consec <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_accept;
      if (w_accept) begin
        r_exp_ts     <= exp_ts;
        r_exp_mask   <= exp_mask;
        r_exp_target <= exp_target;
        r_exp_consec <= exp_consec;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [CNT_W-1:0] r_cnt, w_cnt_next;
      logic             w_match;

      assign w_match = ((remote_ts[gi*TS_W +: TS_W] & r_exp_mask) == (r_exp_ts & r_exp_mask));

      always_comb begin
        w_cnt_next = r_cnt;
        if (!w_count_en || !lane_en[gi]) begin
          w_cnt_next = '0;
        end else if (remote_ts_valid[gi]) begin
          if (w_match) begin
            w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
          end else if (r_exp_consec) begin
            w_cnt_next = '0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_next;
        end
      end

      assign w_lane_done_next[gi] = w_count_en & lane_en[gi] & (w_cnt_next >= r_exp_target);

`ifdef TSA_LANE_CAPTURE_EN
      logic       r_vld;
      logic [7:0] r_link, r_lane;
      logic       w_hit;

      assign w_hit = w_count_en & lane_en[gi] & remote_ts_valid[gi] & w_match;

      // Only the first match after an acceptance is captured; values persist past ts_stop.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld  <= 1'b0;
          r_link <= '0;
          r_lane <= '0;
        end else if (w_accept) begin
          r_vld <= 1'b0;
        end else if (w_hit && !r_vld) begin
          r_vld  <= 1'b1;
          r_link <= remote_ts[gi*TS_W + TS_W - 16 +: 8];
          r_lane <= remote_ts[gi*TS_W + TS_W - 24 +: 8];
        end
      end

      assign rcv_vld[gi]           = r_vld;
      assign rcv_link_num[gi*8 +: 8] = r_link;
      assign rcv_lane_num[gi*8 +: 8] = r_lane;
`else
      assign rcv_vld[gi]           = 1'b0;
      assign rcv_link_num[gi*8 +: 8] = 8'h00;
      assign rcv_lane_num[gi*8 +: 8] = 8'h00;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane_done <= '0;
      r_all_done  <= 1'b0;
      r_any_done  <= 1'b0;
    end else begin
      r_lane_done <= w_lane_done_next;
      r_all_done  <= w_gate & (|lane_en) & (&(w_lane_done_next | ~lane_en));
      r_any_done  <= w_gate & (|(w_lane_done_next & lane_en));
    end
  end

  assign exp_update_ack = r_ack;
  assign lane_done      = r_lane_done;
  assign all_done       = r_all_done;
  assign any_done       = r_any_done;

endmodule
